// File: rtl/nf_sume_10g_tx_startup_fsm_if.sv
// Handshake bundle between the GT/QPLL environment and the TX startup sequencer.
// NF_SUME_TX_STARTUP_STATS_EN adds the lock_loss_count statistics signal.
interface nf_sume_10g_tx_startup_fsm_if;
    logic       qplllock;
    logic       tx_resetdone;
    logic       txuserrdy;
    logic       tx_ready;
    logic       tx_fail;
    logic [3:0] retry_count;
`ifdef NF_SUME_TX_STARTUP_STATS_EN
    logic [15:0] lock_loss_count;

    modport master (
        output qplllock, tx_resetdone,
        input  txuserrdy, tx_ready, tx_fail, retry_count, lock_loss_count
    );
    modport slave (
        input  qplllock, tx_resetdone,
        output txuserrdy, tx_ready, tx_fail, retry_count, lock_loss_count
    );
`else
    modport master (
        output qplllock, tx_resetdone,
        input  txuserrdy, tx_ready, tx_fail, retry_count
    );
    modport slave (
        input  qplllock, tx_resetdone,
        output txuserrdy, tx_ready, tx_fail, retry_count
    );
`endif
endinterface

// File: rtl/nf_sume_10g_tx_startup_fsm.sv
// GT TX startup sequencer: QPLL lock -> paced txuserrdy -> wait tx_resetdone (timeout/retry) -> tx_ready.
// Define NF_SUME_TX_STARTUP_STATS_EN to add the saturating lock_loss_count statistic.
module nf_sume_10g_tx_startup_fsm #(
    parameter int SYNC_STAGES       = 4,
    parameter int USERRDY_DELAY     = 16,
    parameter int RESETDONE_TIMEOUT = 65535,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                           txusrclk2,
    input  logic                           gttxreset,
    nf_sume_10g_tx_startup_fsm_if.slave    io_tx
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_DELAY     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RETRY     = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [15:0] DLY_LAST = 16'(USERRDY_DELAY - 1);
    localparam logic [15:0] TO_LAST  = 16'(RESETDONE_TIMEOUT - 1);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_done_sync;
    state_t                 r_state;
    logic [15:0]            r_dly_cnt;
    logic [15:0]            r_to_cnt;
    logic [3:0]             r_retry_cnt;
    logic                   r_txuserrdy;
    logic                   r_tx_ready;
    logic                   r_tx_fail;

    state_t                 w_state_nxt;
    logic [15:0]            w_dly_nxt;
    logic [15:0]            w_to_nxt;
    logic [3:0]             w_retry_nxt;
    logic [3:0]             w_retry_inc;
    logic                   w_lock_s;
    logic                   w_done_s;

    // Both inputs are asynchronous to txusrclk2; only the last chain stage is used.
    always_ff @(posedge txusrclk2 or posedge gttxreset) begin
        if (gttxreset) begin
            r_lock_sync <= '0;
            r_done_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], io_tx.qplllock};
            r_done_sync <= {r_done_sync[SYNC_STAGES-2:0], io_tx.tx_resetdone};
        end
    end

    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_done_s    = r_done_sync[SYNC_STAGES-1];
    assign w_retry_inc = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;

    always_ff @(posedge txusrclk2 or posedge gttxreset) begin
        if (gttxreset) begin
            r_state     <= ST_WAIT_LOCK;
            r_dly_cnt   <= '0;
            r_to_cnt    <= '0;
            r_retry_cnt <= '0;
            r_txuserrdy <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_tx_fail   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dly_cnt   <= w_dly_nxt;
            r_to_cnt    <= w_to_nxt;
            r_retry_cnt <= w_retry_nxt;
            // Outputs decode the next state so they change on the same edge as the state.
            r_txuserrdy <= (w_state_nxt == ST_WAIT_DONE) || (w_state_nxt == ST_READY);
            r_tx_ready  <= (w_state_nxt == ST_READY);
            r_tx_fail   <= (w_state_nxt == ST_FAIL);
        end
    end

    // Lock loss is tested first in every lockable state so it wins over all other exits.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly_cnt;
        w_to_nxt    = r_to_cnt;
        w_retry_nxt = r_retry_cnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_DELAY;
                    w_dly_nxt   = '0;
                end
            end
            ST_DELAY: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_dly_cnt == DLY_LAST) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_to_nxt    = '0;
                end else begin
                    w_dly_nxt = r_dly_cnt + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_done_s) begin
                    w_state_nxt = ST_READY;
                end else if (r_to_cnt == TO_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = (w_retry_inc >= MAX_R) ? ST_FAIL : ST_RETRY;
                    w_dly_nxt   = '0;
                end else begin
                    w_to_nxt = r_to_cnt + 16'd1;
                end
            end
            ST_RETRY: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_dly_cnt == DLY_LAST) begin
                    w_state_nxt = ST_DELAY;
                    w_dly_nxt   = '0;
                end else begin
                    w_dly_nxt = r_dly_cnt + 16'd1;
                end
            end
            ST_READY: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (!w_done_s) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_to_nxt    = '0;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    assign io_tx.txuserrdy   = r_txuserrdy;
    assign io_tx.tx_ready    = r_tx_ready;
    assign io_tx.tx_fail     = r_tx_fail;
    assign io_tx.retry_count = r_retry_cnt;

`ifdef NF_SUME_TX_STARTUP_STATS_EN
    logic [15:0] r_lock_loss_cnt;
    logic        w_lock_lost;

    assign w_lock_lost = !w_lock_s &&
                         ((r_state == ST_DELAY) || (r_state == ST_WAIT_DONE) ||
                          (r_state == ST_RETRY) || (r_state == ST_READY));

    always_ff @(posedge txusrclk2 or posedge gttxreset) begin
        if (gttxreset) begin
            r_lock_loss_cnt <= '0;
        end else if (w_lock_lost && (r_lock_loss_cnt != 16'hFFFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
        end
    end

    assign io_tx.lock_loss_count = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_nf_sume_10g_tx_startup_fsm.sv
// Directed bench for nf_sume_10g_tx_startup_fsm; also checks lock_loss_count when
// NF_SUME_TX_STARTUP_STATS_EN is defined.
module tb_nf_sume_10g_tx_startup_fsm;
    localparam int T = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    nf_sume_10g_tx_startup_fsm_if tx_if();

    nf_sume_10g_tx_startup_fsm #(
        .SYNC_STAGES(4), .USERRDY_DELAY(16), .RESETDONE_TIMEOUT(T), .MAX_RETRIES(3)
    ) dut (
        .txusrclk2 (clk),
        .gttxreset (rst),
        .io_tx     (tx_if.slave)
    );

    always #5 clk = ~clk;

    // Returns 1 time unit after the n-th rising edge so inputs/outputs are away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic ready,
                           input logic fail, input logic [3:0] rc);
        chk({tag, ".txuserrdy"},   16'(tx_if.txuserrdy),   16'(rdy));
        chk({tag, ".tx_ready"},    16'(tx_if.tx_ready),    16'(ready));
        chk({tag, ".tx_fail"},     16'(tx_if.tx_fail),     16'(fail));
        chk({tag, ".retry_count"}, 16'(tx_if.retry_count), 16'(rc));
    endtask

    task automatic chk_llc(input string tag, input logic [15:0] exp);
`ifdef NF_SUME_TX_STARTUP_STATS_EN
        chk({tag, ".lock_loss_count"}, tx_if.lock_loss_count, exp);
`else
        if (exp == 16'hFFFF) $display("unused %s", tag);
`endif
    endtask

    initial begin
        tx_if.qplllock     = 1'b0;
        tx_if.tx_resetdone = 1'b0;
        #2;
        chk_out("reset", 0, 0, 0, 4'd0);
        chk_llc("reset", 16'd0);
        tick(10);
        rst = 1'b0;
        tick(2);

        // Lock at cycle 0 -> txuserrdy at cycle 21; resetdone at cycle 30 -> tx_ready at 35
        tx_if.qplllock = 1'b1;
        tick(20); chk_out("lock.c20", 0, 0, 0, 4'd0);
        tick(1);  chk_out("lock.c21", 1, 0, 0, 4'd0);
        tick(9);  tx_if.tx_resetdone = 1'b1;
        tick(4);  chk_out("done.c34", 1, 0, 0, 4'd0);
        tick(1);  chk_out("done.c35", 1, 1, 0, 4'd0);

        // resetdone drop in READY -> back to WAIT_DONE, txuserrdy held
        tx_if.tx_resetdone = 1'b0;
        tick(4);  chk_out("dfall.c4", 1, 1, 0, 4'd0);
        tick(1);  chk_out("dfall.c5", 1, 0, 0, 4'd0);
        tx_if.tx_resetdone = 1'b1;
        tick(4);  chk_out("drise.c4", 1, 0, 0, 4'd0);
        tick(1);  chk_out("drise.c5", 1, 1, 0, 4'd0);

        // 1-cycle lock glitch in READY
        tx_if.qplllock = 1'b0;
        tick(1);  tx_if.qplllock = 1'b1;
        tick(3);  chk_out("lloss.c4", 1, 1, 0, 4'd0);
        tick(1);  chk_out("lloss.c5", 0, 0, 0, 4'd0);
        chk_llc("lloss", 16'd1);
        tick(16); chk_out("relock.c21", 0, 0, 0, 4'd0);
        tick(1);  chk_out("relock.c22", 1, 0, 0, 4'd0);
        tick(1);  chk_out("relock.c23", 1, 1, 0, 4'd0);

        // Timeouts: WAIT_DONE entered 5 edges after resetdone falls
        tx_if.tx_resetdone = 1'b0;
        tick(5);     chk_out("to1.enter", 1, 0, 0, 4'd0);
        tick(T - 1); chk_out("to1.last",  1, 0, 0, 4'd0);
        tick(1);     chk_out("to1.fire",  0, 0, 0, 4'd1);
        tick(31);    chk_out("to1.rdly",  0, 0, 0, 4'd1);
        tick(1);     chk_out("to2.enter", 1, 0, 0, 4'd1);
        tick(T);     chk_out("to2.fire",  0, 0, 0, 4'd2);
        tick(32);    chk_out("to3.enter", 1, 0, 0, 4'd2);
        tick(T);     chk_out("to3.fire",  0, 0, 1, 4'd3);
        tx_if.qplllock = 1'b0;
        tick(100);   chk_out("fail.hold", 0, 0, 1, 4'd3);
        chk_llc("fail", 16'd1);

        // Async reset from FAIL, then clean restart
        rst = 1'b1;
        #1;          chk_out("rst_fail", 0, 0, 0, 4'd0);
        chk_llc("rst_fail", 16'd0);
        tx_if.qplllock = 1'b1;
        tick(1);     rst = 1'b0;
        tick(20);    chk_out("restart.c20", 0, 0, 0, 4'd0);
        tick(1);     chk_out("restart.c21", 1, 0, 0, 4'd0);

        // done_s rises in the exact timeout cycle: done wins
        tick(T - 5); tx_if.tx_resetdone = 1'b1;
        tick(4);     chk_out("race.pre", 1, 0, 0, 4'd0);
        tick(1);     chk_out("race.hit", 1, 1, 0, 4'd0);

        // Lock loss from READY, re-lock, then async reset mid-DELAY
        tx_if.qplllock = 1'b0;
        tick(5);     chk_out("lloss2", 0, 0, 0, 4'd0);
        chk_llc("lloss2", 16'd1);
        tick(3);     tx_if.qplllock = 1'b1;
        tick(10);    chk_out("middelay", 0, 0, 0, 4'd0);
        rst = 1'b1;
        #1;          chk_out("rst_delay", 0, 0, 0, 4'd0);
        chk_llc("rst_delay", 16'd0);
        tick(1);     rst = 1'b0;
        tick(20);    chk_out("restart2.c20", 0, 0, 0, 4'd0);
        tick(1);     chk_out("restart2.c21", 1, 0, 0, 4'd0);
        tick(1);     chk_out("restart2.c22", 1, 1, 0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
